soc_system_cpu_s0_ocimem_access_ctrl: RTL
=========================================

# soc_system_cpu_s0_ocimem_access_ctrl

Debug-memory access sequencer for the cpu_s0 on-chip instrumentation. It consumes the system-clock-domain JTAG decode outputs (`jdo`, `take_action_ocimem_a/b`, `take_no_action_ocimem_a`) and turns them into single-beat Avalon-MM reads and writes on the debug RAM/bus. It returns `MonDReg`, `monitor_ready` and `monitor_error` for the JTAG capture path.

## Interface
- ADDR_W, 10, word-address width of the debug bus
- TIMEOUT, 255, maximum consecutive `avm_waitrequest`-high cycles before an access is aborted (1..65535)

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- reset  in  1  asynchronous, active-high reset
- jdo  in  38  JTAG data word, valid on any strobe cycle
- take_action_ocimem_a  in  1  one-cycle strobe: load address/control
- take_action_ocimem_b  in  1  one-cycle strobe: write data at the current address
- take_no_action_ocimem_a  in  1  one-cycle strobe: read at the current address (streaming)
- avm_address  out  ADDR_W  word address
- avm_read  out  1  read request
- avm_write  out  1  write request
- avm_writedata  out  32  write data
- avm_readdata  in  32  read data, valid when `avm_read`=1 and `avm_waitrequest`=0
- avm_waitrequest  in  1  slave stall
- MonDReg  out  32  monitor data register
- monitor_ready  out  1  1 = idle, last operation finished
- monitor_error  out  1  sticky error (timeout or overrun)

## Operation
- State machine states: IDLE, RD, WR.
- Registers: MonAReg[ADDR_W-1:0], MonDReg[31:0], timeout counter (16 bit), ready, error.
- Strobe priority when several strobes arrive in one cycle: ocimem_a > ocimem_b > no_action_ocimem_a. Lower-priority strobes are ignored and do not raise an error.
- **ocimem_a in IDLE:**
  - MonAReg <= jdo[ADDR_W+1:2].
  - If jdo[16]=1, error is cleared.
  - If jdo[17]=1, the block issues a read at the new address and enters RD. Otherwise it stays in IDLE and ready remains 1.
- **ocimem_b in IDLE:**
  - MonDReg <= jdo[34:3] and avm_writedata <= jdo[34:3].
  - The block enters WR.
- **no_action_ocimem_a in IDLE:** the block enters RD at MonAReg.
- **Entering RD or WR:** ready <= 0 and the timeout counter is cleared.
- **RD:**
  - `avm_read`=1 and `avm_address`=MonAReg.
  - On a cycle with waitrequest=0: MonDReg <= avm_readdata, MonAReg <= MonAReg+1, ready <= 1, return to IDLE.
- **WR:** same as RD with `avm_write`=1. On a cycle with waitrequest=0: MonAReg <= MonAReg+1, ready <= 1, return to IDLE.
- **Timeout:**
  - Each cycle in RD or WR with waitrequest=1 increments the counter.
  - When the counter reaches TIMEOUT, the request drops the next cycle, error <= 1, ready <= 1, and the state returns to IDLE.
  - On timeout, MonDReg and MonAReg are unchanged.
- Address increment wraps modulo 2^ADDR_W (all-ones -> 0).
- **Overrun:** any strobe while in RD or WR is dropped and sets error <= 1. If that strobe is an ocimem_a with jdo[16]=1, error still becomes 1 (set wins over clear).
- Reset mid-access: the request deasserts immediately (asynchronously) and all registers return to reset values.

## Timing
- Reset values: state IDLE, `avm_read`=0, `avm_write`=0, `avm_address`=0, `avm_writedata`=0, `MonDReg`=0, `monitor_ready`=1, `monitor_error`=0.
- Strobe in cycle N -> `avm_read`/`avm_write` high from cycle N+1.
- Zero-wait access: request high only in N+1. MonDReg, ready and the address increment are visible in N+2.
- With k waitrequest-high cycles (k < TIMEOUT): request high in N+1..N+1+k, and completion results are visible in N+2+k.
- Timeout: request high for exactly TIMEOUT cycles, and error=1, ready=1 are visible in N+1+TIMEOUT.
- `avm_address` and `avm_writedata` are stable for the whole time the request is asserted.
- A new strobe is accepted at the earliest in the cycle in which ready reads 1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset, then address load and read:** drive ocimem_a with jdo[11:2]=0x005 and jdo[17]=1, slave returns 0xDEADBEEF with 0 waits -> `avm_read` high 1 cycle at address 0x005, MonDReg=0xDEADBEEF, MonAReg=0x006, ready=1 two cycles after the strobe.
- **Streaming write then read:** ocimem_b with jdo[34:3]=0x12345678 at address 0x3FF -> write at 0x3FF with data 0x12345678, then MonAReg wraps to 0x000. A following no_action_ocimem_a reads from 0x000.
- **Wait states:** waitrequest held for 3 cycles on a read -> `avm_read` high 4 cycles, address and data stable throughout, result valid on the 5th cycle after the strobe.
- **Timeout:** TIMEOUT=8 with waitrequest stuck at 1 -> `avm_read` high exactly 8 cycles, error=1, ready=1, MonDReg unchanged. A following ocimem_a with jdo[16]=1 and jdo[17]=0 clears error.
- **Overrun and priority:** ocimem_b during RD -> dropped, error=1, no write issued. ocimem_a and ocimem_b in the same idle cycle -> only the address load happens.
- **Reset mid-write:** assert reset while `avm_write`=1 and waitrequest=1 -> `avm_write` drops with no clock edge, and all outputs are at their reset values.

Source files
------------

// File: rtl/soc_system_cpu_s0_ocimem_access_ctrl.sv
// Debug-memory access sequencer: turns JTAG ocimem strobes into single-beat
// Avalon-MM reads/writes and keeps MonAReg/MonDReg plus ready/error status.
module soc_system_cpu_s0_ocimem_access_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  // state | meaning
  // IDLE  | no access outstanding, strobes accepted
  // RD    | read request on the bus, waiting for waitrequest low
  // WR    | write request on the bus, waiting for waitrequest low
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  localparam logic [15:0]       CNT_LAST = 16'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_mon_a, w_mon_a_nxt;
  logic [31:0]       r_mon_d, w_mon_d_nxt;
  logic [31:0]       r_wdata, w_wdata_nxt;
  logic [15:0]       r_cnt, w_cnt_nxt;
  logic              r_ready, w_ready_nxt;
  logic              r_error, w_error_nxt;
  logic              w_strobe;
  logic              w_unused_jdo;

  assign w_strobe     = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign w_unused_jdo = ^jdo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_mon_a <= '0;
      r_mon_d <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mon_a <= w_mon_a_nxt;
      r_mon_d <= w_mon_d_nxt;
      r_wdata <= w_wdata_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_ready_nxt;
      r_error <= w_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mon_a_nxt = r_mon_a;
    w_mon_d_nxt = r_mon_d;
    w_wdata_nxt = r_wdata;
    w_cnt_nxt   = r_cnt;
    w_ready_nxt = r_ready;
    w_error_nxt = r_error;
    case (r_state)
      IDLE: begin
        if (take_action_ocimem_a) begin
          w_mon_a_nxt = jdo[ADDR_W+1:2];
          if (jdo[16]) w_error_nxt = 1'b0;
          if (jdo[17]) begin
            w_state_nxt = RD;
            w_ready_nxt = 1'b0;
            w_cnt_nxt   = '0;
          end
        end else if (take_action_ocimem_b) begin
          w_mon_d_nxt = jdo[34:3];
          w_wdata_nxt = jdo[34:3];
          w_state_nxt = WR;
          w_ready_nxt = 1'b0;
          w_cnt_nxt   = '0;
        end else if (take_no_action_ocimem_a) begin
          w_state_nxt = RD;
          w_ready_nxt = 1'b0;
          w_cnt_nxt   = '0;
        end
      end
      RD, WR: begin
        if (!avm_waitrequest) begin
          if (r_state == RD) w_mon_d_nxt = avm_readdata;
          w_mon_a_nxt = r_mon_a + ADDR_ONE;
          w_ready_nxt = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          // abort: leave MonAReg/MonDReg untouched so the host sees the stale pair
          w_error_nxt = 1'b1;
          w_ready_nxt = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
        if (w_strobe) w_error_nxt = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign avm_read      = (r_state == RD);
  assign avm_write     = (r_state == WR);
  assign avm_address   = r_mon_a;
  assign avm_writedata = r_wdata;
  assign MonDReg       = r_mon_d;
  assign monitor_ready = r_ready;
  assign monitor_error = r_error;

endmodule
